// File: rtl/wave_udp_tx_pkg.sv
// Shared definitions for the waveform UDP link; the DA receive side imports the same package
// so both ends agree on FSM encoding defaults and header byte layout.
package wave_udp_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrStart,
    StHdrSend,
    StDataWait,
    StDataStart,
    StDataSend
  } state_e;

  localparam int unsigned PktBytesDef = 1024;
  localparam int unsigned HdrBytesDef = 4;
  localparam int unsigned CntWDef     = 13;

  // Frequency word travels high byte first.
  localparam bit HdrMsbFirst = 1'b1;

  function automatic logic [7:0] hdr_byte(input logic [15:0] freq, input logic [15:0] idx);
    logic [7:0] first;
    logic [7:0] second;
    logic [7:0] res;
    first  = HdrMsbFirst ? freq[15:8] : freq[7:0];
    second = HdrMsbFirst ? freq[7:0] : freq[15:8];
    if (idx == 16'd0) begin
      res = first;
    end else if (idx == 16'd1) begin
      res = second;
    end else begin
      res = 8'h00;
    end
    return res;
  endfunction

endpackage

// File: rtl/wave_udp_tx_if.sv
// Byte-wide UDP transmit core handshake: master is the packet source, slave is the UDP core.
interface wave_udp_tx_if;

  logic        udp_tx_start_en;
  logic [15:0] udp_tx_byte_num;
  logic        udp_tx_req;
  logic [7:0]  udp_tx_data;
  logic        udp_tx_done;

  modport master (
    output udp_tx_start_en,
    output udp_tx_byte_num,
    output udp_tx_data,
    input  udp_tx_req,
    input  udp_tx_done
  );

  modport slave (
    input  udp_tx_start_en,
    input  udp_tx_byte_num,
    input  udp_tx_data,
    output udp_tx_req,
    output udp_tx_done
  );

endinterface

// File: rtl/wave_udp_tx_hdr_mux.sv
// Header payload byte select: frequency word bytes first, zero padding after.
module wave_udp_tx_hdr_mux
  import wave_udp_tx_pkg::*;
#(
  parameter int unsigned HDR_BYTES = HdrBytesDef
) (
  input  logic [15:0] freq,
  input  logic [15:0] idx,
  output logic [7:0]  sel_byte
);

  localparam logic [15:0] HdrLen = 16'(HDR_BYTES);

  always_comb begin
    sel_byte = 8'h00;
    if (idx < HdrLen) begin
      sel_byte = hdr_byte(freq, idx);
    end
  end

endmodule

// File: rtl/wave_udp_tx.sv
// Acquisition-side transmit controller: one header packet per session (or per freq_update),
// then fixed-length waveform packets drained from the sample FIFO.
module wave_udp_tx
  import wave_udp_tx_pkg::*;
#(
  parameter int unsigned PKT_BYTES = PktBytesDef,
  parameter int unsigned HDR_BYTES = HdrBytesDef,
  parameter int unsigned CNT_W     = CntWDef
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_enable,
  input  logic [15:0]      freq_word,
  input  logic             freq_update,
  input  logic [CNT_W-1:0] rd_data_count,
  input  logic [7:0]       fifo_dout,
  output logic             fifo_rd_en,
  output logic             hdr_sent,
  wave_udp_tx_if.master    udp
);

  localparam logic [15:0] PktLen = 16'(PKT_BYTES);
  localparam logic [15:0] HdrLen = 16'(HDR_BYTES);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] freq_q;
  logic        resend_q;
  logic        rd_q;
  logic [7:0]  hdr_data_q;
  logic [7:0]  hdr_next;
  logic        pkt_ready;

  assign pkt_ready = 32'(rd_data_count) >= PKT_BYTES;

  // Combinational so the FIFO's one-cycle read latency lines up with the core's data slot.
  always_comb begin
    fifo_rd_en = 1'b0;
    if (state_q == StDataSend && udp.udp_tx_req && (cnt_q < PktLen)) begin
      fifo_rd_en = 1'b1;
    end
  end

  // Unqualified or excess requests leave both sources at zero, giving 0x00 on the bus.
  assign udp.udp_tx_data = rd_q ? fifo_dout : hdr_data_q;

  wave_udp_tx_hdr_mux #(
    .HDR_BYTES (HDR_BYTES)
  ) u_hdr_mux (
    .freq     (freq_q),
    .idx      (cnt_q),
    .sel_byte (hdr_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= StIdle;
      cnt_q               <= 16'd0;
      freq_q              <= 16'd0;
      resend_q            <= 1'b0;
      rd_q                <= 1'b0;
      hdr_data_q          <= 8'h00;
      hdr_sent            <= 1'b0;
      udp.udp_tx_start_en <= 1'b0;
      udp.udp_tx_byte_num <= 16'd0;
    end else begin
      udp.udp_tx_start_en <= 1'b0;
      rd_q                <= fifo_rd_en;
      hdr_data_q          <= 8'h00;

      unique case (state_q)
        StIdle: begin
          hdr_sent <= 1'b0;
          if (tx_enable) begin
            state_q             <= StHdrStart;
            udp.udp_tx_start_en <= 1'b1;
            udp.udp_tx_byte_num <= HdrLen;
          end
        end

        StHdrStart: begin
          freq_q   <= freq_word;
          resend_q <= 1'b0;
          cnt_q    <= 16'd0;
          state_q  <= StHdrSend;
        end

        StHdrSend: begin
          if (udp.udp_tx_req && (cnt_q < HdrLen)) begin
            hdr_data_q <= hdr_next;
            cnt_q      <= cnt_q + 16'd1;
          end
          if (udp.udp_tx_done) begin
            hdr_sent <= 1'b1;
            state_q  <= StDataWait;
          end
        end

        StDataWait: begin
          if (!tx_enable) begin
            hdr_sent <= 1'b0;
            state_q  <= StIdle;
          end else if (resend_q) begin
            state_q             <= StHdrStart;
            udp.udp_tx_start_en <= 1'b1;
            udp.udp_tx_byte_num <= HdrLen;
          end else if (pkt_ready) begin
            state_q             <= StDataStart;
            udp.udp_tx_start_en <= 1'b1;
            udp.udp_tx_byte_num <= PktLen;
          end
        end

        StDataStart: begin
          cnt_q   <= 16'd0;
          state_q <= StDataSend;
        end

        StDataSend: begin
          if (fifo_rd_en) begin
            cnt_q <= cnt_q + 16'd1;
          end
          if (udp.udp_tx_done) begin
            state_q <= StDataWait;
          end
        end

        default: state_q <= StIdle;
      endcase

      // A request landing on the HDR_START cycle survives the clear and forces a second header.
      if (freq_update) begin
        resend_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/wave_udp_tx.md
Name: wave_udp_tx

Overview:
- Transmit-side counterpart of the DA receive controller; sits on the A/B (acquisition) board between the sample FIFO and the byte-wide UDP transmit core.
- On enable, sends one header packet carrying the 16-bit frequency word, MSB first, zero-padded.
- Then streams fixed-length waveform packets, each read byte-for-byte from the sample FIFO whenever a full packet is buffered.

Parameters:
- PKT_BYTES, 1024, payload bytes per waveform packet (≥2, ≤ FIFO depth).
- HDR_BYTES, 4, payload bytes of the header packet (≥2); bytes beyond the first 2 are 0x00.
- CNT_W, 13, width of the FIFO read-side data count.

Ports:
- clk  in  1  system clock (same domain as UDP tx core and FIFO read side).
- rst_n  in  1  asynchronous active-low reset.
- tx_enable  in  1  level; 1 = stream running.
- freq_word  in  16  frequency word sent in the header; sampled at header start.
- freq_update  in  1  pulse; request a header resend with a new freq_word.
- rd_data_count  in  CNT_W  sample FIFO read-side occupancy.
- fifo_dout  in  8  sample FIFO read data (1-cycle latency after fifo_rd_en).
- fifo_rd_en  out  1  sample FIFO read enable.
- udp_tx_start_en  out  1  one-cycle packet-start pulse to the UDP core.
- udp_tx_byte_num  out  16  payload length; held stable from start pulse to done.
- udp_tx_req  in  1  UDP core byte request; data expected on the following cycle.
- udp_tx_data  out  8  payload byte.
- udp_tx_done  in  1  one-cycle pulse, packet fully sent.
- hdr_sent  out  1  level; header of the current session has completed.

Behaviour:
- Reset values: fifo_rd_en=0, udp_tx_start_en=0, udp_tx_byte_num=0, udp_tx_data=0, hdr_sent=0, state IDLE, byte counter 0, resend flag 0.
- Reset asserted mid-packet aborts immediately. No FIFO flush is performed; the UDP core is reset by the same rst_n.
- FSM states: IDLE, HDR_START, HDR_SEND, DATA_WAIT, DATA_START, DATA_SEND.
- IDLE:
  - tx_enable=1 → HDR_START.
  - hdr_sent cleared on entry to IDLE.
- HDR_START:
  - One-cycle udp_tx_start_en=1 and udp_tx_byte_num=HDR_BYTES.
  - freq_word latched into an internal register; resend flag cleared.
  - → HDR_SEND.
- HDR_SEND:
  - Each udp_tx_req increments the byte index.
  - The cycle after a req, udp_tx_data = latched[15:8] for index 0, latched[7:0] for index 1, 0x00 for all later indices.
  - On udp_tx_done: hdr_sent=1; → DATA_WAIT.
- DATA_WAIT:
  - tx_enable=0 → IDLE.
  - Else resend flag set → HDR_START.
  - Else rd_data_count ≥ PKT_BYTES → DATA_START.
  - Else hold.
- DATA_START:
  - One-cycle udp_tx_start_en=1 and udp_tx_byte_num=PKT_BYTES; byte counter cleared.
  - → DATA_SEND.
- DATA_SEND:
  - fifo_rd_en = udp_tx_req AND (counter < PKT_BYTES), combinational.
  - udp_tx_data = fifo_dout, which arrives aligned with the UDP core's one-cycle-after-req expectation.
  - Counter increments per qualified req.
  - On udp_tx_done → DATA_WAIT.
- Excess udp_tx_req beyond the packet length (header or data): no FIFO read, data 0x00, counter saturates.
- udp_tx_req outside HDR_SEND/DATA_SEND is ignored; fifo_rd_en=0.
- tx_enable deasserted mid-packet: the current packet completes; the FSM then returns to IDLE via DATA_WAIT (or via DATA_WAIT after the header). No truncated packets are sent.
- freq_update:
  - Sets the resend flag in any state.
  - Pulse in IDLE: flag cleared by the next HDR_START.
  - Pulse coincident with HDR_START: flag set after the clear, so the header is sent twice. This is accepted.
- udp_tx_byte_num is registered and changes only in HDR_START/DATA_START.
- FIFO underrun cannot occur: a full packet is guaranteed before start. The FIFO must never be read while empty.
- Counters: CNT_W/16-bit unsigned; comparisons unsigned; no wrap inside a packet.

Decomposition:
- Shared package: FSM state encoding, HDR_BYTES/PKT_BYTES defaults, header byte order constant (MSB first). The same package is used by the DA receive side so both ends agree on header layout.
- No sub-module required. Optional small hdr_mux sub-block for the header byte select; inline is acceptable.

Test Plan:
- Enable with freq_word=0x1F40, HDR_BYTES=4 → start pulse, byte_num=4, bytes 0x1F,0x40,0x00,0x00; hdr_sent=1 after done.
- FIFO preloaded with 1024 bytes 0x00..0xFF repeating, rd_data_count=1024 after header → one data packet, byte_num=1024, bytes in FIFO order, exactly 1024 fifo_rd_en cycles.
- rd_data_count=1023 → no start pulse. Raise to 1024 → start pulse within 2 cycles.
- freq_update with freq_word=0x0FA0 during a data packet → that packet completes; next packet is a header 0x0F,0xA0,0,0 before any further data.
- tx_enable dropped at byte 500 of a data packet → all 1024 bytes sent; FSM to IDLE; hdr_sent=0. Re-enable → header sent first.
- rst_n low at byte 10 of a data packet → all outputs at reset values asynchronously. After release with tx_enable=1 → fresh header packet.
